// File: rtl/deserializer_controller.sv
// rtl/deserializer_controller.sv - link phit deserializer feeding the router input FIFO
// Assembles MSB-first phits into flits; one-flit output holding register decouples assembly from FIFO backpressure.
module deserializer_controller #(
  parameter int INPUT_SIZE  = 4,
  parameter int OUTPUT_SIZE = 32,
  localparam int PHIT_NUMBER = OUTPUT_SIZE / INPUT_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INPUT_SIZE-1:0]  phit_in,
  input  logic                   phit_valid,
  input  logic                   fifo_full,
  output logic                   write_fifo,
  output logic [OUTPUT_SIZE-1:0] flit_out,
  output logic                   deserializer_idle,
  output logic                   overflow
);

  localparam int CW = $clog2(PHIT_NUMBER);

  typedef enum logic [1:0] {IDLE, RECEIVING, FLIT_DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [OUTPUT_SIZE-1:0] shift;
  logic                   pending;
  logic [OUTPUT_SIZE-1:0] next_shift;
  logic                   last_phit;

  assign next_shift        = {shift[OUTPUT_SIZE-INPUT_SIZE-1:0], phit_in};
  assign last_phit         = (state == RECEIVING) && phit_valid && (count == CW'(PHIT_NUMBER - 1));
  assign write_fifo        = pending & ~fifo_full;
  assign deserializer_idle = (state == IDLE) & ~pending;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      shift    <= '0;
      flit_out <= '0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (phit_valid) shift <= next_shift;

      case (state)
        IDLE: begin
          if (phit_valid) begin
            count <= CW'(1);
            state <= RECEIVING;
          end
        end
        RECEIVING: begin
          if (phit_valid) begin
            if (count == CW'(PHIT_NUMBER - 1)) begin
              count <= '0;
              state <= FLIT_DONE;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        FLIT_DONE: begin
          if (phit_valid) begin
            count <= CW'(1);
            state <= RECEIVING;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A completed flit may reuse the holding register only if it is empty or draining this edge.
      if (last_phit && (!pending || write_fifo)) begin
        flit_out <= next_shift;
        pending  <= 1'b1;
      end else begin
        if (write_fifo) pending  <= 1'b0;
        if (last_phit)  overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deserializer_controller.sv
// tb/tb_deserializer_controller.sv - scoreboard bench for deserializer_controller
module tb_deserializer_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  phit_in = '0;
  logic        phit_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic        write_fifo;
  logic [31:0] flit_out;
  logic        deserializer_idle;
  logic        overflow;

  deserializer_controller dut (
    .clk               (clk),
    .reset             (reset),
    .phit_in           (phit_in),
    .phit_valid        (phit_valid),
    .fifo_full         (fifo_full),
    .write_fifo        (write_fifo),
    .flit_out          (flit_out),
    .deserializer_idle (deserializer_idle),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: nibbles of the flit in progress, holding register contents, drop flag.
  logic [3:0]  m_nib[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_out = '0;
  logic        m_pending = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;

  logic        chk_en = 1'b0;
  logic        exp_write, exp_idle, exp_ovf;
  logic [31:0] exp_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic        wr;
    logic [31:0] flit;
    logic        done_n;
    wr = m_pending && !fifo_full;
    if (!reset) begin
      m_nib.delete();
      exp_q.delete();
      m_out = '0;
      m_pending = 1'b0;
      m_ovf = 1'b0;
      m_done = 1'b0;
    end else begin
      done_n = 1'b0;
      flit = '0;
      if (phit_valid) begin
        m_nib.push_back(phit_in);
        if (m_nib.size() == 8) begin
          foreach (m_nib[k]) flit = flit * 16 + 32'(m_nib[k]);
          m_nib.delete();
          done_n = 1'b1;
        end
      end
      if (done_n) begin
        if (!m_pending || wr) begin
          m_out = flit;
          m_pending = 1'b1;
          exp_q.push_back(flit);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (wr) begin
        m_pending = 1'b0;
      end
      m_done = done_n;
    end
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic f);
    phit_valid = v;
    phit_in    = d;
    fifo_full  = f;
    exp_write  = m_pending && !f;
    exp_idle   = (m_nib.size() == 0) && !m_done && !m_pending;
    exp_out    = m_out;
    exp_ovf    = m_ovf;
    chk_en     = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), f);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) step(1'b1, 4'($urandom), 1'b0);
    reset = 1'b1;
  endtask

  task automatic send_flit(input logic [31:0] w, input logic [7:0] gaps, input logic f, input logic f_last);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, w[31-4*i -: 4], (i == 7) ? f_last : f);
      if (gaps[i]) step(1'b0, 4'($urandom), f);
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on every FIFO write.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("write_fifo", 32'(write_fifo), 32'(exp_write));
      chk("idle", 32'(deserializer_idle), 32'(exp_idle));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("flit_out_hold", flit_out, exp_out);
      if (write_fifo === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: flit_out %h with empty scoreboard at %0t", flit_out, $time);
        end else begin
          chk("written_flit", flit_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset(2);
    idle(3, 1'b0);

    send_flit(32'h12345678, 8'h00, 1'b0, 1'b0);
    idle(3, 1'b0);

    send_flit(32'hA5A5A5A5, 8'h00, 1'b0, 1'b0);
    send_flit(32'h0F0F0F0F, 8'h00, 1'b0, 1'b0);
    idle(3, 1'b0);
    send_flit(32'hA5A5A5A5, 8'b0010_0100, 1'b0, 1'b0);
    send_flit(32'h0F0F0F0F, 8'b0010_0100, 1'b0, 1'b0);
    idle(3, 1'b0);

    send_flit(32'hDEADBEEF, 8'h00, 1'b1, 1'b1);
    idle(5, 1'b1);
    idle(3, 1'b0);

    send_flit(32'h11111111, 8'h00, 1'b1, 1'b1);
    send_flit(32'h22222222, 8'h00, 1'b1, 1'b1);
    idle(3, 1'b1);
    idle(3, 1'b0);
    do_reset(1);
    send_flit(32'h11111111, 8'h00, 1'b1, 1'b1);
    send_flit(32'h22222222, 8'h00, 1'b1, 1'b0);
    idle(3, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 9), 1'b0);
    do_reset(1);
    send_flit(32'hCAFEF00D, 8'h00, 1'b0, 1'b0);
    idle(3, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset(1);
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) == 0);
    end
    idle(4, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected flits never written", exp_q.size());
    end
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializer_controller.md
Name: deserializer_controller

Overview:
- Receive-side counterpart of the link serializer. Accepts 4-bit phits from the link, assembles 8 consecutive phits into one 32-bit flit, and writes the flit into the downstream input FIFO.
- Sits between the link wires and the router input FIFO.
- Double-buffered so the next flit can assemble while the previous one waits on a full FIFO.

Parameters:
- INPUT_SIZE, 4, phit width in bits.
- OUTPUT_SIZE, 32, flit width in bits.
- PHIT_NUMBER, OUTPUT_SIZE/INPUT_SIZE (8), phits per flit; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- phit_in  input  INPUT_SIZE  phit data from link; sampled only when phit_valid=1.
- phit_valid  input  1  phit_in carries a valid phit this cycle.
- fifo_full  input  1  downstream FIFO cannot accept a write this cycle.
- write_fifo  output  1  write strobe to FIFO; flit_out is valid while high.
- flit_out  output  OUTPUT_SIZE  assembled flit (output holding register).
- deserializer_idle  output  1  no partial flit and no pending flit.
- overflow  output  1  sticky; a completed flit was dropped.

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE, phit counter=0, shift register=0, flit_out=0, pending=0, overflow=0.
  - Outputs during reset: write_fifo=0, deserializer_idle=1.
  - Reset overrides every other event in the same cycle.
- Assembly order: MSB-first. Each accepted phit updates shift <= {shift[OUTPUT_SIZE-INPUT_SIZE-1:0], phit_in]}. The first phit ends up in flit bits [31:28], the eighth in [3:0].
- Counter: 3 bits, counts accepted phits in the current flit.
  - Holds when phit_valid=0; gaps between phits are legal in any state.
  - Wraps to 0 after the 8th phit.
- State machine:
  - IDLE: phit_valid=1 -> accept phit, counter=1, go RECEIVING. Otherwise stay.
  - RECEIVING, phit_valid=1 and counter!=7: accept phit, counter+1, stay.
  - RECEIVING, phit_valid=1 and counter==7: accept the 8th phit, then go to FLIT_DONE with counter=0. The completed flit = {shift[27:0], phit_in}.
  - FLIT_DONE (one cycle):
    - Transfer the completed flit to the output register (rules below).
    - phit_valid=1 -> accept it as the first phit of the next flit, counter=1, go RECEIVING.
    - phit_valid=0 -> go IDLE.
- Output register / handshake:
  - Combinational write_fifo = pending & ~fifo_full.
  - A FIFO write occurs on any posedge with write_fifo=1; pending clears at that edge unless a new load occurs at the same edge.
  - flit_out stays stable while pending=1.
  - Load on FLIT_DONE entry, i.e. the edge accepting the 8th phit:
    - pending=0, or pending=1 with write_fifo=1 at that same edge: flit_out <= completed flit, pending <= 1. No loss.
    - pending=1 with fifo_full=1: completed flit discarded, flit_out unchanged, overflow <= 1 (sticky until reset).
- Latency: 8th phit sampled at edge N -> flit_out valid and write_fifo=1 in the cycle after edge N, provided fifo_full=0.
- Throughput: back-to-back phits sustain 1 flit per 8 cycles, with no bubble required.
- deserializer_idle = (state==IDLE) & ~pending.
- Reset mid-flit: the partial flit is discarded and the pending flit is lost. No write_fifo pulse occurs in the cycle after reset is released.
- The block never stalls the link: there is no backpressure toward the serializer.

Test Plan:
- Reset: hold reset=0 for 2 cycles with phit_valid=1 -> write_fifo=0, flit_out=0x00000000, deserializer_idle=1, overflow=0; after release, no write until 8 phits are received.
- Single flit: phits 1,2,3,4,5,6,7,8 on consecutive cycles, fifo_full=0 -> exactly one write_fifo pulse, in the cycle after the 8th phit, with flit_out=0x12345678; then deserializer_idle=1.
- Back-to-back and gapped: 16 continuous phits forming 0xA5A5A5A5 then 0x0F0F0F0F -> two write pulses exactly 8 cycles apart with the correct values. Repeat with phit_valid=0 inserted after phits 3 and 6 -> same flits, each write delayed by 2 cycles.
- Backpressure: fifo_full=1 during flit 0xDEADBEEF, released 5 cycles after completion -> write_fifo stays 0 with flit_out=0xDEADBEEF held; one pulse when fifo_full drops; overflow=0.
- Overflow: fifo_full=1 permanently, send 0x11111111 then 0x22222222 -> flit_out remains 0x11111111, overflow=1 from the edge after the 16th phit. Same case but fifo_full drops on the completion cycle of the second flit -> no overflow, 0x22222222 loaded.
- Mid-flit reset: assert reset=0 after 5 phits, then send 0xCAFEF00D -> only 0xCAFEF00D is written; no partial-flit write.
